// File: rtl/divisor_secuencial.sv
// Iterative unsigned restoring divider: one quotient bit per clock, start/done handshake.
// Divide-by-zero short-circuits to DONE with an all-ones quotient and DIVZ set.
module divisor_secuencial #(
   parameter int BIT = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [BIT-1:0] num1,
   input  logic [BIT-1:0] num2,
   output logic           busy,
   output logic           done,
   output logic [BIT-1:0] Quotient,
   output logic [BIT-1:0] Remainder,
   output logic           DIVZ
);

   localparam int CNT_W = (BIT > 2) ? $clog2(BIT) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r;
   logic [BIT-1:0]   dvd_r;
   logic [BIT-1:0]   dvs_r;
   logic [BIT:0]     rem_r;
   logic [CNT_W-1:0] cnt_r;

   logic [BIT:0]     shift_s;
   logic [BIT+1:0]   trial_s;
   logic             qbit_s;
   logic [BIT:0]     rem_next_s;
   logic [BIT-1:0]   dvd_next_s;

   // One restoring step; the extra trial bit is the sign of (shifted remainder - divisor)
   always_comb begin
      shift_s    = {rem_r[BIT-1:0], dvd_r[BIT-1]};
      trial_s    = {1'b0, shift_s} - {2'b00, dvs_r};
      qbit_s     = ~trial_s[BIT+1];
      rem_next_s = qbit_s ? trial_s[BIT:0] : shift_s;
      dvd_next_s = {dvd_r[BIT-2:0], qbit_s};
   end

   // Control FSM with datapath registers and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         dvd_r     <= {BIT{1'b0}};
         dvs_r     <= {BIT{1'b0}};
         rem_r     <= {(BIT+1){1'b0}};
         cnt_r     <= {CNT_W{1'b0}};
         busy      <= 1'b0;
         done      <= 1'b0;
         Quotient  <= {BIT{1'b0}};
         Remainder <= {BIT{1'b0}};
         DIVZ      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  if (num2 == {BIT{1'b0}}) begin
                     Quotient  <= {BIT{1'b1}};
                     Remainder <= num1;
                     DIVZ      <= 1'b1;
                     done      <= 1'b1;
                     state_r   <= DONE;
                  end else begin
                     dvd_r   <= num1;
                     dvs_r   <= num2;
                     rem_r   <= {(BIT+1){1'b0}};
                     cnt_r   <= {CNT_W{1'b0}};
                     busy    <= 1'b1;
                     state_r <= CALC;
                  end
               end
            end
            CALC: begin
               rem_r <= rem_next_s;
               dvd_r <= dvd_next_s;
               cnt_r <= cnt_r + CNT_W'(1);
               if (cnt_r == CNT_W'(BIT-1)) begin
                  Quotient  <= dvd_next_s;
                  Remainder <= rem_next_s[BIT-1:0];
                  DIVZ      <= 1'b0;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state_r   <= DONE;
               end
            end
            DONE: begin
               done    <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               busy    <= 1'b0;
               done    <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_divisor_secuencial.sv
// Directed self-checking bench for divisor_secuencial (BIT=4), including an operand sweep.
module tb_divisor_secuencial;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [3:0] num1;
   logic [3:0] num2;
   logic       busy;
   logic       done;
   logic [3:0] Quotient;
   logic [3:0] Remainder;
   logic       DIVZ;

   int checks = 0;
   int errors = 0;

   divisor_secuencial #(.BIT(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num1(num1), .num2(num2),
      .busy(busy), .done(done), .Quotient(Quotient), .Remainder(Remainder), .DIVZ(DIVZ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) until done is sampled high; n counts edges waited.
   task automatic wait_done(output int n);
      n = 0;
      while (done !== 1'b1 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   // One division: lat = edges from accept edge to done, bcnt = samples with busy high,
   // dn2 = done one cycle after it was first seen.
   task automatic run(input logic [3:0] a, input logic [3:0] b,
                      output int lat, output int bcnt, output logic dn2);
      @(negedge clk);
      num1 = a; num2 = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0; bcnt = 0;
      while (done !== 1'b1 && lat < 40) begin
         if (busy === 1'b1) bcnt++;
         @(posedge clk); #1;
         lat++;
      end
      @(posedge clk); #1;
      dn2 = done;
   endtask

   initial begin
      int   lat, bcnt, n;
      logic dn2;
      rst_n = 1'b0; start = 1'b0; num1 = 4'd0; num2 = 4'd0;

      repeat (2) @(posedge clk); #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_q", Quotient, 0);
      chk("rst_r", Remainder, 0);
      chk("rst_divz", DIVZ, 0);
      @(negedge clk); rst_n = 1'b1;

      // 8/2 -> 4 r0, four edges of latency
      run(4'd8, 4'd2, lat, bcnt, dn2);
      chk("8_2_lat", lat, 4);
      chk("8_2_q", Quotient, 4'b0100);
      chk("8_2_r", Remainder, 0);
      chk("8_2_divz", DIVZ, 0);

      // 13/4 -> 3 r1, busy four cycles, single-cycle done
      run(4'd13, 4'd4, lat, bcnt, dn2);
      chk("13_4_q", Quotient, 3);
      chk("13_4_r", Remainder, 1);
      chk("13_4_divz", DIVZ, 0);
      chk("13_4_busy_cycles", bcnt, 4);
      chk("13_4_done_pulse", dn2, 0);

      run(4'd15, 4'd1, lat, bcnt, dn2);
      chk("15_1_q", Quotient, 15);
      chk("15_1_r", Remainder, 0);
      run(4'd3, 4'd9, lat, bcnt, dn2);
      chk("3_9_q", Quotient, 0);
      chk("3_9_r", Remainder, 3);
      run(4'd15, 4'd15, lat, bcnt, dn2);
      chk("15_15_q", Quotient, 1);
      chk("15_15_r", Remainder, 0);

      // divide by zero: done right after accept, busy never high
      run(4'd7, 4'd0, lat, bcnt, dn2);
      chk("7_0_lat", lat, 0);
      chk("7_0_q", Quotient, 4'b1111);
      chk("7_0_r", Remainder, 7);
      chk("7_0_divz", DIVZ, 1);
      chk("7_0_busy", bcnt, 0);
      chk("7_0_done_pulse", dn2, 0);
      run(4'd6, 4'd3, lat, bcnt, dn2);
      chk("6_3_q", Quotient, 2);
      chk("6_3_r", Remainder, 0);
      chk("6_3_divz", DIVZ, 0);

      // start held high with operand changes during CALC
      @(negedge clk);
      num1 = 4'd13; num2 = 4'd4; start = 1'b1;
      @(posedge clk); #1;
      num1 = 4'd15; num2 = 4'd1;
      wait_done(n);
      chk("hold_lat", n, 4);
      chk("hold_q", Quotient, 3);
      chk("hold_r", Remainder, 1);
      @(posedge clk); #1;
      chk("hold_done_ignored_busy", busy, 0);
      chk("hold_done_low", done, 0);
      @(posedge clk); #1;
      chk("hold_idle_accept", busy, 1);
      start = 1'b0;
      wait_done(n);
      chk("hold_second_q", Quotient, 15);
      chk("hold_second_r", Remainder, 0);
      @(posedge clk); #1;

      // asynchronous reset in step 2 of 13/4
      @(negedge clk);
      num1 = 4'd13; num2 = 4'd4; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_q", Quotient, 0);
      chk("abort_r", Remainder, 0);
      chk("abort_divz", DIVZ, 0);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         chk("abort_no_done", done, 0);
         if (i == 2) rst_n = 1'b1;
      end
      run(4'd9, 4'd2, lat, bcnt, dn2);
      chk("9_2_q", Quotient, 4);
      chk("9_2_r", Remainder, 1);

      // exhaustive sweep
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            run(4'(a), 4'(b), lat, bcnt, dn2);
            if (b != 0) begin
               chk("sweep_identity", 32'(Quotient) * 32'(b) + 32'(Remainder), 32'(a));
               chk("sweep_r_lt_d", 32'(Remainder < 4'(b)), 1);
               chk("sweep_q", 32'(Quotient), 32'(a / b));
            end else begin
               chk("sweep_divz", {Quotient, Remainder, 3'b000, DIVZ}, {4'hF, 4'(a), 4'h1});
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
